// File: rtl/pe_o_drain.sv
// Output drain for a PE column: counts accumulator beats, quantises the capture beat and queues results in a show-ahead FIFO.
// Optional rounding (round half up) is enabled by defining PE_DRAIN_RND_EN; otherwise results truncate toward -inf.
module pe_o_drain #(
    parameter int ACC_BW = 32,
    parameter int MUL_BW = 16,
    parameter int FRA_BW = 6,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [15:0]              k_len,
    input  logic [7:0]               n_out,
    input  logic                     o_vld_i,
    input  logic signed [ACC_BW-1:0] o_i,
    output logic signed [MUL_BW-1:0] res_o,
    output logic                     res_vld_o,
    input  logic                     res_rdy_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     ovf_o,
    output logic                     sat_o,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

`ifdef PE_DRAIN_RND_EN
    localparam logic signed [ACC_BW:0] RND = (ACC_BW+1)'(2 ** (FRA_BW - 1));
`else
    localparam logic signed [ACC_BW:0] RND = '0;
`endif
    localparam logic signed [ACC_BW:0] Q_MAX = (ACC_BW+1)'(2 ** (MUL_BW - 1) - 1);
    localparam logic signed [ACC_BW:0] Q_MIN = ~Q_MAX;

    state_t state, state_n;
    logic   done_n;
    logic [15:0] k_lat, beat_cnt;
    logic [7:0]  n_lat, res_cnt;

    logic [MUL_BW-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              empty, full, pop, push, drop, cap;

    // One extra bit of headroom so the rounding add can never wrap.
    logic signed [ACC_BW:0] ext, q_full;
    logic                   sat_hit;
    logic [MUL_BW-1:0]      q;

    always_comb begin
        ext     = {o_i[ACC_BW-1], o_i} + RND;
        q_full  = ext >>> FRA_BW;
        sat_hit = (q_full > Q_MAX) || (q_full < Q_MIN);
        if (q_full > Q_MAX)      q = Q_MAX[MUL_BW-1:0];
        else if (q_full < Q_MIN) q = Q_MIN[MUL_BW-1:0];
        else                     q = q_full[MUL_BW-1:0];
    end

    // Handshake: a FIFO entry transfers on a cycle where res_vld_o && res_rdy_i;
    // res_o is stable while res_vld_o is high and not yet accepted.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign res_vld_o = !empty;
    assign res_o     = empty ? '0 : $signed(mem[rd_ptr[AW-1:0]]);
    assign pop       = res_vld_o && res_rdy_i;
    assign cap       = (state == ACC) && o_vld_i && (beat_cnt == k_lat - 16'd1);
    assign push      = cap && (!full || pop);
    assign drop      = cap && full && !pop;
    assign busy_o    = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (k_len == 16'd0 || n_out == 8'd0) done_n  = 1'b1;
                    else                                 state_n = ACC;
                end
            end
            ACC: begin
                if (cap && (res_cnt + 8'd1 == n_lat)) state_n = DRAIN;
            end
            DRAIN: begin
                if (empty) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            done_o   <= 1'b0;
            k_lat    <= '0;
            n_lat    <= '0;
            beat_cnt <= '0;
            res_cnt  <= '0;
            ovf_o    <= 1'b0;
            sat_o    <= 1'b0;
        end else begin
            state  <= state_n;
            done_o <= done_n;
            if (state == IDLE && start) begin
                k_lat    <= k_len;
                n_lat    <= n_out;
                beat_cnt <= '0;
                res_cnt  <= '0;
                ovf_o    <= 1'b0;
                sat_o    <= 1'b0;
            end else if (cap) begin
                beat_cnt <= '0;
                res_cnt  <= res_cnt + 8'd1;
                if (sat_hit) sat_o <= 1'b1;
                if (drop)    ovf_o <= 1'b1;
            end else if (state == ACC && o_vld_i) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end

    // FIFO storage survives job starts; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= q;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_pe_o_drain.sv
// Directed bench for pe_o_drain: quantisation vector table plus hand-written job sequences.
module tb_pe_o_drain;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] k_len;
    logic [7:0]  n_out;
    logic        o_vld_i;
    logic [31:0] o_i;
    logic [15:0] res_o;
    logic        res_vld_o;
    logic        res_rdy_i;
    logic        busy_o, done_o, ovf_o, sat_o;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [31:0] o_val;
        logic [15:0] res;
        logic        sat;
    } vec_t;
    vec_t vecs[12];

    pe_o_drain dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .n_out(n_out),
        .o_vld_i(o_vld_i), .o_i(o_i), .res_o(res_o), .res_vld_o(res_vld_o),
        .res_rdy_i(res_rdy_i), .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o),
        .sat_o(sat_o), .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Check any pop happening at the coming edge, advance, then sample 1ns after the edge.
    task automatic tick();
        if (res_vld_o && res_rdy_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got %h want none", res_o);
            end else begin
                chk("pop_data", {16'h0, res_o}, {16'h0, exp_q.pop_front()});
            end
        end
        @(posedge clk);
        #1;
        if (done_o) done_cnt++;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done_o && n < 60) begin
            tick();
            n++;
        end
        chk(name, {31'h0, done_o}, 32'h1);
        chk({name, "_busy"}, {31'h0, busy_o}, 32'h0);
    endtask

    initial begin
`ifdef PE_DRAIN_RND_EN
        vecs[0]  = '{32'h0000_0140, 16'h0005, 1'b0};
        vecs[1]  = '{32'h0000_0020, 16'h0001, 1'b0};
        vecs[2]  = '{32'hFFFF_FFE0, 16'h0000, 1'b0};
        vecs[3]  = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1};
        vecs[4]  = '{32'h8000_0000, 16'h8000, 1'b1};
        vecs[5]  = '{32'h0000_0FC0, 16'h003F, 1'b0};
        vecs[6]  = '{32'h001F_FFC0, 16'h7FFF, 1'b0};
        vecs[7]  = '{32'h0020_0000, 16'h7FFF, 1'b1};
        vecs[8]  = '{32'hFFE0_0000, 16'h8000, 1'b0};
        vecs[9]  = '{32'hFFDF_FFC0, 16'h8000, 1'b1};
        vecs[10] = '{32'h0000_0030, 16'h0001, 1'b0};
        vecs[11] = '{32'hFFFF_FFD0, 16'hFFFF, 1'b0};
`else
        vecs[0]  = '{32'h0000_0140, 16'h0005, 1'b0};
        vecs[1]  = '{32'h0000_0020, 16'h0000, 1'b0};
        vecs[2]  = '{32'hFFFF_FFE0, 16'hFFFF, 1'b0};
        vecs[3]  = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1};
        vecs[4]  = '{32'h8000_0000, 16'h8000, 1'b1};
        vecs[5]  = '{32'h0000_0FC0, 16'h003F, 1'b0};
        vecs[6]  = '{32'h001F_FFC0, 16'h7FFF, 1'b0};
        vecs[7]  = '{32'h0020_0000, 16'h7FFF, 1'b1};
        vecs[8]  = '{32'hFFE0_0000, 16'h8000, 1'b0};
        vecs[9]  = '{32'hFFDF_FFC0, 16'h8000, 1'b1};
        vecs[10] = '{32'h0000_0030, 16'h0000, 1'b0};
        vecs[11] = '{32'hFFFF_FFD0, 16'hFFFF, 1'b0};
`endif

        rst = 1'b1; start = 1'b0; k_len = '0; n_out = '0;
        o_vld_i = 1'b0; o_i = '0; res_rdy_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld",  {31'h0, res_vld_o}, 32'h0);
        chk("rst_res",  {16'h0, res_o}, 32'h0);
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_done", {31'h0, done_o}, 32'h0);
        chk("rst_ovf",  {31'h0, ovf_o}, 32'h0);
        chk("rst_sat",  {31'h0, sat_o}, 32'h0);
        rst = 1'b0;
        tick();

        // Quantisation / saturation table: one single-beat job per vector.
        res_rdy_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            k_len = 16'd1; n_out = 8'd1; start = 1'b1;
            tick();
            start = 1'b0;
            chk("vec_busy", {31'h0, busy_o}, 32'h1);
            chk("vec_sat_clr", {31'h0, sat_o}, 32'h0);
            o_vld_i = 1'b1; o_i = vecs[i].o_val;
            exp_q.push_back(vecs[i].res);
            tick();
            o_vld_i = 1'b0;
            chk("vec_vld", {31'h0, res_vld_o}, 32'h1);
            chk("vec_sat", {31'h0, sat_o}, {31'h0, vecs[i].sat});
            wait_done("vec_done");
        end
        chk("vec_q_empty", exp_q.size(), 32'h0);

        // k_len=3, n_out=2: capture on every third beat, done exactly once.
        done_cnt = 0;
        k_len = 16'd3; n_out = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(16'd5);
        exp_q.push_back(16'd5);
        o_i = 32'h140;
        for (int i = 0; i < 6; i++) begin
            o_vld_i = 1'b1;
            tick();
        end
        o_vld_i = 1'b0;
        wait_done("k3_done");
        tick();
        tick();
        chk("k3_done_once", done_cnt, 32'h1);
        chk("k3_q_empty", exp_q.size(), 32'h0);

        // Overflow: 6 captures into a 4-deep FIFO with no reader.
        res_rdy_i = 1'b0;
        k_len = 16'd1; n_out = 8'd6; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            o_vld_i = 1'b1; o_i = 32'(i) << 6;
            if (i <= 4) exp_q.push_back(16'(i));
            tick();
            if (i == 4) chk("ovf_before", {31'h0, ovf_o}, 32'h0);
            if (i == 5) chk("ovf_after", {31'h0, ovf_o}, 32'h1);
        end
        o_vld_i = 1'b0;
        chk("ovf_drain_busy", {31'h0, busy_o}, 32'h1);
        res_rdy_i = 1'b1;
        wait_done("ovf_done");
        chk("ovf_q_empty", exp_q.size(), 32'h0);
        chk("ovf_sticky", {31'h0, ovf_o}, 32'h1);

        // Full FIFO with same-cycle capture and pop; a start mid-ACC is ignored.
        res_rdy_i = 1'b0;
        k_len = 16'd1; n_out = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("full_ovf_clr", {31'h0, ovf_o}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            o_vld_i = 1'b1; o_i = 32'(10 + i) << 6;
            exp_q.push_back(16'(10 + i));
            if (i == 1) begin
                start = 1'b1; k_len = 16'd0; n_out = 8'd0;
            end
            tick();
            start = 1'b0;
            if (i == 1) begin
                chk("start_ignored_busy", {31'h0, busy_o}, 32'h1);
                chk("start_ignored_done", {31'h0, done_o}, 32'h0);
            end
        end
        o_vld_i = 1'b1; o_i = 32'd14 << 6; res_rdy_i = 1'b1;
        exp_q.push_back(16'd14);
        tick();
        o_vld_i = 1'b0;
        chk("full_pop_ovf", {31'h0, ovf_o}, 32'h0);
        chk("full_pop_state", {30'h0, dbg_state}, 32'h2);
        wait_done("full_done");
        chk("full_q_empty", exp_q.size(), 32'h0);

        // Reset mid-ACC with two entries queued, then a zero-length job.
        res_rdy_i = 1'b0;
        k_len = 16'd1; n_out = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        o_vld_i = 1'b1; o_i = 32'h40;
        tick();
        o_i = 32'h80;
        tick();
        o_vld_i = 1'b0;
        chk("pre_rst_vld", {31'h0, res_vld_o}, 32'h1);
        chk("pre_rst_busy", {31'h0, busy_o}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", {31'h0, res_vld_o}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy_o}, 32'h0);
        chk("mid_rst_res", {16'h0, res_o}, 32'h0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        k_len = 16'd1; n_out = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_done", {31'h0, done_o}, 32'h1);
        chk("zero_busy", {31'h0, busy_o}, 32'h0);
        tick();
        chk("zero_done_pulse", {31'h0, done_o}, 32'h0);
        chk("zero_busy_after", {31'h0, busy_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
